v_query_pipe: RTL and testbench
===============================

# v_query_pipe

Read-side companion to the update pipe: services lookup queries against the per-ID state table that the update pipe writes. Issues one state-table read per accepted query, corrects the returned word against concurrent update-pipe writes, and delivers responses in order through a ready/valid buffered response port. Sits beside the update pipe on the shared state RAM: the update pipe owns the write port; this block owns the read port and snoops the write port.

## Interface
- ID_W, 4, query/state address width (table depth 2^ID_W)
- KEY_W, 32, key field width
- SIZE_W, 16, size field width
- RSP_DEPTH, 4, response buffer entries (legal ≥ 2)
- STATE_W = 1+KEY_W+SIZE_W (derived). State word layout is fixed:
  - [STATE_W-1] = valid
  - [KEY_W+SIZE_W-1:SIZE_W] = key
  - [SIZE_W-1:0] = size

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_qry_vld  in  1  query request valid
- i_qry_id  in  ID_W  queried ID
- o_qry_rdy  out  1  query accepted when vld&rdy
- o_state_ren  out  1  state read enable
- o_state_raddr  out  ID_W  state read address
- i_state_rdata  in  STATE_W  read data, valid cycle after ren
- i_state_wen  in  1  snooped update-pipe write enable
- i_state_waddr  in  ID_W  snooped write address
- i_state_wdata  in  STATE_W  snooped write data
- o_rsp_vld  out  1  response valid
- i_rsp_rdy  in  1  response consumed when vld&rdy
- o_rsp_id  out  ID_W  echoed ID
- o_rsp_hit  out  1  entry valid bit
- o_rsp_key  out  KEY_W  entry key
- o_rsp_size  out  SIZE_W  entry size
- o_hit_cnt  out  16  saturating count of popped hit responses

## Operation
- Accept: o_qry_rdy = (rsp_cnt + s1_vld) < RSP_DEPTH, using registered values only (no same-cycle pop lookahead).
- Issue (S0): o_state_ren = i_qry_vld & o_qry_rdy; o_state_raddr = i_qry_id (combinational).
- S1: registered s1_vld and s1_id; i_state_rdata arrives.
- RAM read-during-write to the same address returns OLD data.
- Data selection at S1, highest priority first:
  1. Write in S1 cycle with waddr==s1_id: take that cycle's wdata.
  2. Write in S0 cycle with waddr==raddr: take wdata captured into S1.
  3. Otherwise: i_state_rdata.
- S1 result pushes into the in-order RSP_DEPTH FIFO. Writes after the push are not reflected; the response is a snapshot.
- Response fields are driven from the FIFO head; pop occurs on o_rsp_vld & i_rsp_rdy.
- o_hit_cnt increments on each pop with hit=1 and saturates at 16'hFFFF.
- Push and pop in the same cycle leave rsp_cnt unchanged. The FIFO never overflows by construction of o_qry_rdy.

## Timing
- Latency: query accepted in cycle N; o_rsp_vld=1 in cycle N+2 if the FIFO was empty.
- With RSP_DEPTH ≥ 3 and i_rsp_rdy held 1, sustained throughput is one query per cycle.
- With RSP_DEPTH = 2, throughput is 2 queries per 3 cycles.
- Response fields are stable while o_rsp_vld=1 and i_rsp_rdy=0.
- Reset (asynchronous, any time including mid-operation):
  - s1_vld, rsp_cnt, FIFO pointers, and o_hit_cnt clear to 0.
  - Outputs: o_rsp_vld=0, o_rsp_* = 0, o_state_ren=0, o_qry_rdy=0.
  - o_qry_rdy is 1 from the first cycle after deassertion.
  - In-flight queries are dropped.

## Configuration
- V_QUERY_BYPASS_EN defined: write-snoop correction as described; the i_state_w* ports are used.
- Not defined: S1 result is always i_state_rdata. The snoop ports remain on the interface but are unused. Responses may then be stale relative to writes in cycles N and N+1.

## Test plan
- Single query, no backpressure: state[3]={1,32'hCAFE0001,16'h0040}; query id 3 at cycle 0 -> o_rsp_vld at cycle 2 with hit=1, key=CAFE0001, size=0x40; o_hit_cnt=1 after the pop.
- Back-to-back: ids 0..7 on consecutive cycles, i_rsp_rdy=1, RSP_DEPTH=4 -> o_qry_rdy never drops; 8 in-order responses on cycles 2..9.
- Backpressure: i_rsp_rdy=0 with continuous queries -> exactly 4 accepted, then o_qry_rdy=0; raise rdy -> responses drain in order and nothing is lost.
- Bypass: write id 5 = {1,K2,S2} in the issue cycle, then a separate query with a write in the S1 cycle -> both responses return the written data. With V_QUERY_BYPASS_EN undefined, the first returns the old RAM data.
- Reset mid-stream: assert rst with 3 responses buffered and 1 in S1 -> o_rsp_vld=0 and o_hit_cnt=0 immediately; no stale response appears after deassertion.
- Counter saturation: preload condition of 65535 hits plus 2 more hit pops -> o_hit_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/v_query_pipe_if.sv
// Query, state-RAM and response signals of v_query_pipe.
// master = the query pipe itself; slave = host, state RAM and response consumer.
interface v_query_pipe_if #(
   parameter int ID_W   = 4,
   parameter int KEY_W  = 32,
   parameter int SIZE_W = 16
);
   localparam int STATE_W = 1 + KEY_W + SIZE_W;

   // Handshakes: a transfer happens in any cycle where valid and ready are both 1;
   // valid never waits on ready, and payload is held while valid=1 and ready=0.
   logic               i_qry_vld;
   logic [ID_W-1:0]    i_qry_id;
   logic               o_qry_rdy;
   logic               o_state_ren;
   logic [ID_W-1:0]    o_state_raddr;
   logic [STATE_W-1:0] i_state_rdata;
   logic               i_state_wen;
   logic [ID_W-1:0]    i_state_waddr;
   logic [STATE_W-1:0] i_state_wdata;
   logic               o_rsp_vld;
   logic               i_rsp_rdy;
   logic [ID_W-1:0]    o_rsp_id;
   logic               o_rsp_hit;
   logic [KEY_W-1:0]   o_rsp_key;
   logic [SIZE_W-1:0]  o_rsp_size;
   logic [15:0]        o_hit_cnt;

   modport master (
      input  i_qry_vld, i_qry_id, i_state_rdata, i_state_wen, i_state_waddr,
             i_state_wdata, i_rsp_rdy,
      output o_qry_rdy, o_state_ren, o_state_raddr, o_rsp_vld, o_rsp_id,
             o_rsp_hit, o_rsp_key, o_rsp_size, o_hit_cnt
   );

   modport slave (
      output i_qry_vld, i_qry_id, i_state_rdata, i_state_wen, i_state_waddr,
             i_state_wdata, i_rsp_rdy,
      input  o_qry_rdy, o_state_ren, o_state_raddr, o_rsp_vld, o_rsp_id,
             o_rsp_hit, o_rsp_key, o_rsp_size, o_hit_cnt
   );
endinterface

// File: rtl/v_query_pipe.sv
// Per-ID state lookup pipe: one RAM read per query, in-order buffered responses.
// Optional write-snoop correction of read data is enabled by V_QUERY_BYPASS_EN.
module v_query_pipe #(
   parameter int ID_W      = 4,
   parameter int KEY_W     = 32,
   parameter int SIZE_W    = 16,
   parameter int RSP_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   v_query_pipe_if.master   bus
);
   localparam int STATE_W = 1 + KEY_W + SIZE_W;
   localparam int ENT_W   = ID_W + STATE_W;
   localparam int PW      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW      = $clog2(RSP_DEPTH + 1);

   logic               s1_vld;
   logic [ID_W-1:0]    s1_id;
   logic [STATE_W-1:0] s1_data;
   logic [CW-1:0]      rsp_cnt;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [ENT_W-1:0]   fifo_mem [RSP_DEPTH];
   logic [ENT_W-1:0]   head;
   logic [15:0]        hit_cnt;
   logic               ren;
   logic               rsp_vld;
   logic               push;
   logic               pop;

   // Accept only when every in-flight query already has a buffer slot reserved.
   assign bus.o_qry_rdy     = ~rst & ((int'(rsp_cnt) + int'(s1_vld)) < RSP_DEPTH);
   assign ren               = bus.i_qry_vld & bus.o_qry_rdy;
   assign bus.o_state_ren   = ren;
   assign bus.o_state_raddr = bus.i_qry_id;

`ifdef V_QUERY_BYPASS_EN
   logic               s1_byp;
   logic [STATE_W-1:0] s1_bdata;

   // A write racing the read in S0 is invisible to the RAM (old-data read), so keep it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_byp   <= 1'b0;
         s1_bdata <= '0;
      end else begin
         s1_byp <= ren & bus.i_state_wen & (bus.i_state_waddr == bus.i_qry_id);
         if (ren & bus.i_state_wen & (bus.i_state_waddr == bus.i_qry_id))
            s1_bdata <= bus.i_state_wdata;
      end
   end

   always_comb begin
      s1_data = bus.i_state_rdata;
      if (s1_byp)
         s1_data = s1_bdata;
      if (bus.i_state_wen && (bus.i_state_waddr == s1_id))
         s1_data = bus.i_state_wdata;
   end
`else
   logic unused_snoop;
   assign unused_snoop = ^{bus.i_state_wen, bus.i_state_waddr, bus.i_state_wdata};
   assign s1_data      = bus.i_state_rdata;
`endif

   assign rsp_vld = (rsp_cnt != '0);
   assign push    = s1_vld;
   assign pop     = rsp_vld & bus.i_rsp_rdy;
   assign head    = fifo_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_id   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rsp_cnt <= '0;
         hit_cnt <= '0;
      end else begin
         s1_vld <= ren;
         if (ren)
            s1_id <= bus.i_qry_id;
         if (push)
            wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         if (push && !pop)
            rsp_cnt <= rsp_cnt + CW'(1);
         else if (pop && !push)
            rsp_cnt <= rsp_cnt - CW'(1);
         if (pop && head[STATE_W-1] && (hit_cnt != 16'hFFFF))
            hit_cnt <= hit_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {s1_id, s1_data};
   end

   // Fields read as zero whenever no response is presented, including during reset.
   assign bus.o_rsp_vld  = rsp_vld;
   assign bus.o_rsp_id   = rsp_vld ? head[ENT_W-1 -: ID_W] : '0;
   assign bus.o_rsp_hit  = rsp_vld & head[STATE_W-1];
   assign bus.o_rsp_key  = rsp_vld ? head[KEY_W+SIZE_W-1:SIZE_W] : '0;
   assign bus.o_rsp_size = rsp_vld ? head[SIZE_W-1:0] : '0;
   assign bus.o_hit_cnt  = hit_cnt;
endmodule

// File: tb/tb_v_query_pipe.sv
// Bench for v_query_pipe: randomized and directed traffic against a table-snapshot
// reference model; honours V_QUERY_BYPASS_EN the same way as the design.
module tb_v_query_pipe;
   localparam int ID_W      = 4;
   localparam int KEY_W     = 32;
   localparam int SIZE_W    = 16;
   localparam int RSP_DEPTH = 4;
   localparam int STATE_W   = 1 + KEY_W + SIZE_W;
   localparam int ENT_W     = ID_W + STATE_W;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   v_query_pipe_if #(.ID_W(ID_W), .KEY_W(KEY_W), .SIZE_W(SIZE_W)) bus ();

   v_query_pipe #(.ID_W(ID_W), .KEY_W(KEY_W), .SIZE_W(SIZE_W), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // state RAM: synchronous read, old data on read-during-write
   logic [STATE_W-1:0] ram [16];
   always @(posedge clk) begin
      if (bus.o_state_ren)
         bus.i_state_rdata <= ram[bus.o_state_raddr];
      if (bus.i_state_wen)
         ram[bus.i_state_waddr] <= bus.i_state_wdata;
   end

   // scoreboard and reference model
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_n = 0;
   int pop_n = 0;
   int exp_hits = 0;
   bit prev_acc = 0;
   logic [ID_W-1:0]    prev_id = '0;
   logic [STATE_W-1:0] tbl [16];
   logic [ENT_W-1:0]   exp_q [$];
   int                 due_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [STATE_W-1:0] rand_word(input bit force_valid);
      logic [STATE_W-1:0] w;
      w = {1'($urandom), $urandom, 16'($urandom)};
      if (force_valid)
         w[STATE_W-1] = 1'b1;
      return w;
   endfunction

   // One clock of traffic: check outputs, drive inputs, advance the model.
   task automatic step(input bit qv, input logic [ID_W-1:0] qid, input bit wv,
                       input logic [ID_W-1:0] wa, input logic [STATE_W-1:0] wd, input bit rr);
      bit m_rdy, m_vld, acc;
      logic [ENT_W-1:0] f;
      @(negedge clk);
      m_rdy = (acc_n - pop_n) < RSP_DEPTH;
      m_vld = (exp_q.size() > 0) && (due_q[0] <= cyc);
      f     = '0;
      check("qry_rdy", 64'(bus.o_qry_rdy), 64'(m_rdy));
      check("rsp_vld", 64'(bus.o_rsp_vld), 64'(m_vld));
      check("hit_cnt", 64'(bus.o_hit_cnt), 64'(exp_hits));
      if (m_vld) begin
         f = exp_q[0];
         check("rsp_id",   64'(bus.o_rsp_id),   64'(f[ENT_W-1 -: ID_W]));
         check("rsp_hit",  64'(bus.o_rsp_hit),  64'(f[STATE_W-1]));
         check("rsp_key",  64'(bus.o_rsp_key),  64'(f[KEY_W+SIZE_W-1:SIZE_W]));
         check("rsp_size", 64'(bus.o_rsp_size), 64'(f[SIZE_W-1:0]));
      end
      bus.i_qry_vld     = qv;
      bus.i_qry_id      = qid;
      bus.i_state_wen   = wv;
      bus.i_state_waddr = wa;
      bus.i_state_wdata = wd;
      bus.i_rsp_rdy     = rr;
      #1;
      acc = qv && m_rdy;
      check("state_ren", 64'(bus.o_state_ren), 64'(acc));
      if (acc)
         check("state_raddr", 64'(bus.o_state_raddr), 64'(qid));
      if (m_vld && rr) begin
         void'(exp_q.pop_front());
         void'(due_q.pop_front());
         pop_n++;
         if (f[STATE_W-1] && exp_hits < 65535)
            exp_hits++;
      end
      // a response is the table as it stands once the query's read has completed
`ifdef V_QUERY_BYPASS_EN
      if (wv)
         tbl[wa] = wd;
      if (prev_acc) begin
         exp_q.push_back({prev_id, tbl[prev_id]});
         due_q.push_back(cyc + 1);
      end
      prev_acc = acc;
      prev_id  = qid;
`else
      if (acc) begin
         exp_q.push_back({qid, tbl[qid]});
         due_q.push_back(cyc + 2);
      end
      if (wv)
         tbl[wa] = wd;
`endif
      if (acc)
         acc_n++;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, '0, 0, '0, '0, 1);
   endtask

   task automatic model_clear();
      exp_q.delete();
      due_q.delete();
      acc_n    = 0;
      pop_n    = 0;
      exp_hits = 0;
      prev_acc = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_vld"},   64'(bus.o_rsp_vld),   64'd0);
      check({tag, "_hit_cnt"},   64'(bus.o_hit_cnt),   64'd0);
      check({tag, "_qry_rdy"},   64'(bus.o_qry_rdy),   64'd0);
      check({tag, "_state_ren"}, 64'(bus.o_state_ren), 64'd0);
      check({tag, "_rsp_fields"},
            64'({bus.o_rsp_id, bus.o_rsp_hit, bus.o_rsp_key, bus.o_rsp_size}), 64'd0);
   endtask

   initial begin
      logic [STATE_W-1:0] k2, k3;
      rst               = 1'b1;
      bus.i_qry_vld     = 1'b1;
      bus.i_qry_id      = '0;
      bus.i_state_wen   = 1'b0;
      bus.i_state_waddr = '0;
      bus.i_state_wdata = '0;
      bus.i_rsp_rdy     = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      bus.i_qry_vld = 1'b0;
      rst           = 1'b0;

      // preload the table through the write port
      for (int i = 0; i < 16; i++)
         step(0, '0, 1, 4'(i), (i == 3) ? {1'b1, 32'hCAFE0001, 16'h0040} : rand_word(0), 1);
      idle(2);

      // single query
      step(1, 4'd3, 0, '0, '0, 1);
      idle(4);
      check("single_hits", 64'(bus.o_hit_cnt), 64'(exp_hits));

      // back-to-back ids 0..7
      for (int i = 0; i < 8; i++)
         step(1, 4'(i), 0, '0, '0, 1);
      idle(4);

      // backpressure then drain
      for (int i = 0; i < 8; i++)
         step(1, 4'($urandom_range(0, 15)), 0, '0, '0, 0);
      idle(8);

      // write-snoop: write in the issue cycle, then in the S1 cycle
      k2 = {1'b1, 32'h0BAD_F00D, 16'h1234};
      k3 = {1'b1, 32'h5EED_0005, 16'h0777};
      step(1, 4'd5, 1, 4'd5, k2, 1);
      idle(2);
      step(1, 4'd5, 0, '0, '0, 1);
      step(0, '0, 1, 4'd5, k3, 1);
      idle(4);

      // randomized traffic with frequent address collisions
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), rand_word(0),
              $urandom_range(0, 9) < 6);
      idle(8);

      // reset mid-stream: three responses buffered, one query in S1
      for (int i = 0; i < 4; i++)
         step(1, 4'($urandom_range(0, 15)), 0, '0, '0, 0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("mid");
      @(negedge clk);
      bus.i_qry_vld = 1'b0;
      bus.i_rsp_rdy = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      idle(6);

      // hit counter saturation
      for (int i = 0; i < 16; i++)
         step(0, '0, 1, 4'(i), rand_word(1), 1);
      for (int i = 0; i < 65540; i++)
         step(1, 4'(i), 0, '0, '0, 1);
      idle(4);
      check("hit_sat", 64'(bus.o_hit_cnt), 64'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
